alu_arbiter_sequencer: RTL

ALU_ARBITER_SEQUENCER -- requirements
Module: alu_arbiter_sequencer

---
 rtl/alu_arbiter_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter_sequencer.sv
// alu_arbiter_sequencer
// Round-robin arbiter in front of a fixed-latency ALU sequencer. Two
// requesters compete for one ALU operation at a time. The winner's command
// is latched at grant and walked through READ_A, READ_B, EXEC, WRITE and DONE,
// one cycle each, driving the register-file decoder and ALU selects.
//
// Ports
//   clk, lowRst                       clock (rising edge), async active-low reset
//   req0/req1                         operation request, held until its grant
//   cmdOp*, cmdSrcA*, cmdSrcB*, cmdDst*  command fields of each requester
//   sOverflow, sCarry, sNegative, sZero  ALU status flags from the datapath
//   gnt0/gnt1                         combinational grant pulse (IDLE only)
//   done0/done1                       registered pulse in the DONE cycle
//   rFlags                            {ovf, carry, neg, zero} captured leaving EXEC
//   sSelDecoA/B/C, sSelAlu            registered decoder and ALU selects
//   busy                              registered, high outside IDLE
module alu_arbiter_sequencer #(
  parameter int unsigned SELECTIONALU  = 3,
  parameter int unsigned SELECTIONDECO = 3
) (
  input  logic                     clk,
  input  logic                     lowRst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [SELECTIONALU-1:0]  cmdOp0,
  input  logic [SELECTIONALU-1:0]  cmdOp1,
  input  logic [SELECTIONDECO-1:0] cmdSrcA0,
  input  logic [SELECTIONDECO-1:0] cmdSrcA1,
  input  logic [SELECTIONDECO-1:0] cmdSrcB0,
  input  logic [SELECTIONDECO-1:0] cmdSrcB1,
  input  logic [SELECTIONDECO-1:0] cmdDst0,
  input  logic [SELECTIONDECO-1:0] cmdDst1,
  input  logic                     sOverflow,
  input  logic                     sCarry,
  input  logic                     sNegative,
  input  logic                     sZero,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     done0,
  output logic                     done1,
  output logic [3:0]               rFlags,
  output logic [SELECTIONDECO-1:0] sSelDecoA,
  output logic [SELECTIONDECO-1:0] sSelDecoB,
  output logic [SELECTIONDECO-1:0] sSelDecoC,
  output logic [SELECTIONALU-1:0]  sSelAlu,
  output logic                     busy
);

  localparam int unsigned AW = SELECTIONALU;
  localparam int unsigned DW = SELECTIONDECO;
  localparam logic [DW-1:0] NO_WRITE = {DW{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          last_q;          // id of the requester served last
  logic          id_q, id_d;
  logic [AW-1:0] op_q, op_d;
  logic [DW-1:0] srca_q, srca_d;
  logic [DW-1:0] srcb_q, srcb_d;
  logic [DW-1:0] dst_q, dst_d;

  logic win0_c, win1_c, grant_c;

  // Round-robin: on a tie the requester not served last wins.
  assign win0_c  = req0 & (~req1 | last_q);
  assign win1_c  = req1 & (~req0 | ~last_q);
  // Grant only from IDLE and never while reset is asserted.
  assign grant_c = lowRst & (state_q == IDLE) & (req0 | req1);
  assign gnt0    = grant_c & win0_c;
  assign gnt1    = grant_c & win1_c;

  // Command seen by the next state: winner's fields at grant, else the latch.
  always_comb begin
    id_d   = id_q;
    op_d   = op_q;
    srca_d = srca_q;
    srcb_d = srcb_q;
    dst_d  = dst_q;
    if (grant_c) begin
      id_d   = win1_c;
      op_d   = win1_c ? cmdOp1   : cmdOp0;
      srca_d = win1_c ? cmdSrcA1 : cmdSrcA0;
      srcb_d = win1_c ? cmdSrcB1 : cmdSrcB0;
      dst_d  = win1_c ? cmdDst1  : cmdDst0;
    end
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = grant_c ? READ_A : IDLE;
      READ_A:  state_d = READ_B;
      READ_B:  state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command, flags and registered Moore outputs. Outputs are
  // decoded from the upcoming state so they line up with the state register.
  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      op_q      <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      dst_q     <= '0;
      rFlags    <= 4'b0000;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      sSelDecoA <= '0;
      sSelDecoB <= '0;
      sSelDecoC <= NO_WRITE;
      sSelAlu   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      dst_q   <= dst_d;
      if (grant_c) begin
        last_q <= win1_c;
      end
      if (state_q == EXEC) begin
        rFlags <= {sOverflow, sCarry, sNegative, sZero};
      end

      busy  <= (state_d != IDLE);
      done0 <= (state_d == DONE) & ~id_d;
      done1 <= (state_d == DONE) &  id_d;

      sSelDecoA <= '0;
      sSelDecoB <= '0;
      sSelDecoC <= NO_WRITE;
      sSelAlu   <= '0;
      case (state_d)
        READ_A: begin
          sSelDecoA <= srca_d;
        end
        READ_B: begin
          sSelDecoA <= srca_d;
          sSelDecoB <= srcb_d;
        end
        EXEC: begin
          sSelDecoA <= srca_d;
          sSelDecoB <= srcb_d;
          sSelAlu   <= op_d;
        end
        WRITE: begin
          // An all-ones destination passes through unchanged: no write, same latency.
          sSelDecoA <= srca_d;
          sSelDecoB <= srcb_d;
          sSelDecoC <= dst_d;
          sSelAlu   <= op_d;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
